// File: rtl/bus_arbiter2_pkg.sv
// Shared constants and state encoding for the two-requester round-robin arbiter.
package bus_arbiter2_pkg;

  localparam int WORD_LENGTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  // Maps a requester index onto its ownership state.
  function automatic arb_state_t own_state(input logic idx);
    return idx ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/bus_arbiter2_mux2.sv
// Two-input word mux steering the owning requester's data to the sink.
module bus_arbiter2_mux2
  import bus_arbiter2_pkg::*;
#(
  parameter int n = WORD_LENGTH
) (
  input  logic         sel,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter2.sv
// Two-requester round-robin arbiter driving one valid/ready word channel.
// Define ARB2_LOCK_EN to add the per-requester burst lock input.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int n = WORD_LENGTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req,
  input  logic [n-1:0] in_data [1:0],
  output logic [1:0]   gnt,
  output logic         sel,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef ARB2_LOCK_EN
  ,
  input  logic [1:0]   lock
`endif
);

  arb_state_t state, state_next;
  logic       last, last_next;
  logic       sel_next;
  logic       owned, owner, xfer, hold;

  assign owned = (state != ARB_IDLE);
  assign owner = (state == ARB_OWN1);

  // A word presented while reset is sampled is dropped, so it is never offered.
  assign out_valid = reset_n & owned & req[owner];
  assign xfer      = out_valid & out_ready;
  assign gnt       = xfer ? (owner ? 2'b10 : 2'b01) : 2'b00;

`ifdef ARB2_LOCK_EN
  assign hold = lock[owner];
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_next = state;
    last_next  = last;
    // Idle and abandoned ownership share the same pick rules.
    if (!owned || !req[owner]) begin
      case (req)
        2'b00:   state_next = ARB_IDLE;
        2'b01:   state_next = ARB_OWN0;
        2'b10:   state_next = ARB_OWN1;
        default: state_next = own_state(~last);
      endcase
    end else if (xfer && !hold) begin
      last_next  = owner;
      state_next = own_state(req[~owner] ? ~owner : owner);
    end
  end

  assign sel_next = (state_next == ARB_IDLE) ? sel : (state_next == ARB_OWN1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
      sel   <= 1'b0;
    end else begin
      state <= state_next;
      last  <= last_next;
      sel   <= sel_next;
    end
  end

  bus_arbiter2_mux2 #(.n(n)) u_mux (
    .sel (sel),
    .a   (in_data[0]),
    .b   (in_data[1]),
    .y   (out_data)
  );

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2 against an index-based round-robin model.
module tb_bus_arbiter2;
  import bus_arbiter2_pkg::*;

  logic                   clk;
  logic                   reset_n;
  logic [1:0]             req;
  logic [WORD_LENGTH-1:0] in_data [1:0];
  logic [1:0]             gnt;
  logic                   sel;
  logic [WORD_LENGTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
`ifdef ARB2_LOCK_EN
  logic [1:0]             lock;
`endif

  int checks = 0;
  int passes = 0;

  // Model state: owner is -1 when nobody owns the channel.
  int m_owner = -1;
  int m_last  = 1;
  int m_sel   = 0;

  bus_arbiter2 #(.n(WORD_LENGTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ARB2_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_locked(input int o);
`ifdef ARB2_LOCK_EN
    return lock[o];
`else
    return (o < 0);
`endif
  endfunction

  function automatic int model_pick();
    if (req == 2'b00) return -1;
    if (req == 2'b11) return 1 - m_last;
    return (req == 2'b01) ? 0 : 1;
  endfunction

  // Expected {out_valid, gnt[1:0], sel} for the current inputs.
  function automatic logic [3:0] model_ctrl();
    logic       v;
    logic [1:0] g;
    v = reset_n && (m_owner >= 0) && req[m_owner];
    g = 2'b00;
    if (v && out_ready) g = (m_owner == 1) ? 2'b10 : 2'b01;
    return {v, g, (m_sel == 1)};
  endfunction

  task automatic model_step();
    logic [3:0] c;
    c = model_ctrl();
    if (!reset_n) begin
      m_owner = -1;
      m_last  = 1;
      m_sel   = 0;
      return;
    end
    if (m_owner < 0 || !req[m_owner]) begin
      m_owner = model_pick();
    end else if (c[3] && out_ready && !model_locked(m_owner)) begin
      m_last = m_owner;
      if (req[1 - m_owner]) m_owner = 1 - m_owner;
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 2'b00;
    out_ready = 1'b0;
`ifdef ARB2_LOCK_EN
    lock      = 2'b00;
`endif
    repeat (2) begin
      @(posedge clk);
      model_step();
      #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_c;
    reset_n    = 1'b0;
    req        = 2'b11;
    out_ready  = 1'b1;
    in_data[0] = 32'h1111_0000;
    in_data[1] = 32'h2222_0001;
`ifdef ARB2_LOCK_EN
    lock       = 2'b00;
`endif
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) reset_n = 1'b1;
      @(negedge clk);
      exp_c = model_ctrl();
      checks++;
      if ({out_valid, gnt, sel} !== exp_c)
        $display("[TB] FAIL reset ctrl cycle %0d: got %b expected %b", i, {out_valid, gnt, sel}, exp_c);
      else passes++;
      if (i < 2) begin
        checks++;
        if ({out_valid, gnt, sel} !== 4'b0000)
          $display("[TB] FAIL reset idle cycle %0d: got %b expected 0000", i, {out_valid, gnt, sel});
        else passes++;
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_c;
    do_reset();
    req        = 2'b10;
    out_ready  = 1'b1;
    in_data[0] = 32'h0BAD_F00D;
    in_data[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_c = model_ctrl();
      checks++;
      if ({out_valid, gnt, sel} !== exp_c)
        $display("[TB] FAIL single ctrl cycle %0d: got %b expected %b", i, {out_valid, gnt, sel}, exp_c);
      else passes++;
      if (i > 0) begin
        checks++;
        if (out_data !== 32'hDEAD_BEEF)
          $display("[TB] FAIL single data cycle %0d: got %h expected deadbeef", i, out_data);
        else passes++;
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_c;
    do_reset();
    req        = 2'b01;
    in_data[0] = 32'hCAFE_0000;
    in_data[1] = 32'h5555_5555;
    for (int i = 0; i < 6; i++) begin
      out_ready = (i == 4);
      if (i == 5) req = 2'b00;
      @(negedge clk);
      exp_c = model_ctrl();
      checks++;
      if ({out_valid, gnt, sel} !== exp_c)
        $display("[TB] FAIL backpressure ctrl cycle %0d: got %b expected %b", i, {out_valid, gnt, sel}, exp_c);
      else passes++;
      checks++;
      if (out_data !== in_data[m_sel])
        $display("[TB] FAIL backpressure data cycle %0d: got %h expected %h", i, out_data, in_data[m_sel]);
      else passes++;
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic test_abandon();
    logic [3:0] exp_c;
    logic       seen1;
    logic [1:0] seq [5];
    seq = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    seen1 = 1'b0;
    do_reset();
    out_ready  = 1'b0;
    in_data[0] = 32'hA0A0_A0A0;
    in_data[1] = 32'hB1B1_B1B1;
    for (int i = 0; i < 5; i++) begin
      req = seq[i];
      @(negedge clk);
      exp_c = model_ctrl();
      checks++;
      if ({out_valid, gnt, sel} !== exp_c)
        $display("[TB] FAIL abandon ctrl cycle %0d: got %b expected %b", i, {out_valid, gnt, sel}, exp_c);
      else passes++;
      seen1 = seen1 | gnt[1];
      @(posedge clk);
      model_step();
      #1;
    end
    checks++;
    if (seen1 !== 1'b0) $display("[TB] FAIL abandon gnt1: got %b expected 0", seen1);
    else passes++;
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_c;
    do_reset();
    out_ready  = 1'b0;
    in_data[0] = 32'h0000_00AA;
    in_data[1] = 32'h0000_00BB;
    for (int i = 0; i < 5; i++) begin
      req       = (i < 3) ? 2'b10 : 2'b00;
      reset_n   = (i != 2);
      out_ready = (i == 2);
      @(negedge clk);
      exp_c = model_ctrl();
      checks++;
      if ({out_valid, gnt, sel} !== exp_c)
        $display("[TB] FAIL midreset ctrl cycle %0d: got %b expected %b", i, {out_valid, gnt, sel}, exp_c);
      else passes++;
      @(posedge clk);
      model_step();
      #1;
    end
    reset_n = 1'b1;
  endtask

`ifdef ARB2_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_c;
    do_reset();
    req        = 2'b11;
    out_ready  = 1'b1;
    lock       = 2'b01;
    in_data[0] = 32'h1234_5678;
    in_data[1] = 32'h8765_4321;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) lock = 2'b00;
      @(negedge clk);
      exp_c = model_ctrl();
      checks++;
      if ({out_valid, gnt, sel} !== exp_c)
        $display("[TB] FAIL lock ctrl cycle %0d: got %b expected %b", i, {out_valid, gnt, sel}, exp_c);
      else passes++;
      if (i >= 1 && i <= 4) begin
        checks++;
        if (gnt !== 2'b01) $display("[TB] FAIL lock hold cycle %0d: got %b expected 01", i, gnt);
        else passes++;
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_c;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset_n    = ($urandom_range(0, 39) != 0);
      req        = 2'($urandom_range(0, 3));
      out_ready  = ($urandom_range(0, 3) != 0);
      in_data[0] = $urandom;
      in_data[1] = $urandom;
`ifdef ARB2_LOCK_EN
      lock       = 2'($urandom_range(0, 3));
`endif
      @(negedge clk);
      exp_c = model_ctrl();
      checks++;
      if ({out_valid, gnt, sel} !== exp_c)
        $display("[TB] FAIL random ctrl cycle %0d: got %b expected %b", i, {out_valid, gnt, sel}, exp_c);
      else passes++;
      checks++;
      if (out_data !== in_data[m_sel])
        $display("[TB] FAIL random data cycle %0d: got %h expected %h", i, out_data, in_data[m_sel]);
      else passes++;
      @(posedge clk);
      model_step();
      #1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    req        = 2'b00;
    out_ready  = 1'b0;
    in_data[0] = '0;
    in_data[1] = '0;
`ifdef ARB2_LOCK_EN
    lock       = 2'b00;
`endif
    $display("[TB] starting bus_arbiter2 bench");
    test_reset();
    test_single();
    test_backpressure();
    test_abandon();
    test_mid_reset();
`ifdef ARB2_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-requester, round-robin arbiter for one shared word-wide output channel. It sequences the select of a 2-input word mux.
- Each requester presents req plus data. The arbiter grants one requester at a time and steers its data to a single valid/ready sink.
- Sits between CPU-internal masters (e.g. fetch and load/store) and a single-ported consumer such as a memory or bus port.

Parameters:
- n, constants::WORD_LENGTH, width of data words in bits

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- req  input  [1:0]  request per requester; held high with stable data until its gnt pulse
- in_data  input  [n-1:0] x2 (unpacked [1:0])  data per requester
- gnt  output  [1:0]  one-cycle acceptance pulse to the requester whose word transferred
- sel  output  1  current owner index; drives the mux select
- out_data  output  [n-1:0]  word from owner (in_data[sel])
- out_valid  output  1  owner has a word for the sink
- out_ready  input  1  sink accepts the word this cycle
- lock  input  [1:0]  burst hold per requester; present only with ARB2_LOCK_EN

Behaviour:
- Interface: one clock clk; reset_n is synchronous, active-low.
- Reset (reset_n low at a clk edge):
  - state=IDLE, sel=0, last=1 (requester 0 wins first tie).
  - out_valid=0, gnt=0.
  - Applies mid-transfer: the pending word is dropped and no gnt is issued.
- States: IDLE, OWN0, OWN1. sel is registered (0 in OWN0, 1 in OWN1) and unchanged in IDLE.
- IDLE:
  - req==00: stay in IDLE.
  - One req bit set: go to that OWNx.
  - req==11: go to OWN(~last).
  - Grant latency is one cycle; out_valid is never asserted in IDLE.
- OWNx:
  - out_valid = req[x] (combinational from the held state).
  - out_data = in_data[x].
  - gnt[x] = out_valid & out_ready; the other gnt bit is 0.
- Transfer: out_valid & out_ready at an edge. On transfer:
  - last <= x.
  - If req[~x]: go to OWN(~x).
  - Else if req[x]: stay in OWNx (back-to-back, 1 word/cycle).
  - Else: go to IDLE.
- Abandon: req[x] low in OWNx with no transfer. Apply the IDLE rules in the same cycle; last is not updated.
- out_ready low while out_valid is high: hold the state; out_data is stable because the requester holds it.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1,...
- Requester protocol: req must stay high until gnt. Dropping req early is legal and is treated as abandon.
- gnt is never asserted to a non-owner, and never to both bits at once.

Optional Feature:
- Macro: ARB2_LOCK_EN.
- Enabled:
  - The lock port exists.
  - On a transfer in OWNx with lock[x]=1 and req[x]=1, stay in OWNx regardless of req[~x], and do not update last.
  - Dropping lock[x] resumes normal round-robin on the next transfer.
- Disabled:
  - No lock port; pure round-robin as above.

Decomposition:
- Package constants:
  - WORD_LENGTH (existing).
  - New arb_state_t enum {ARB_IDLE, ARB_OWN0, ARB_OWN1}, 2-bit.
- Sub-module: instantiate the existing _mux2 utility for out_data, with sel as its select; no other sub-modules.

Test Plan:
- Reset: reset_n=0 for 2 cycles with req=11 -> out_valid=0, gnt=00, sel=0. Release with req=11, out_ready=1 -> out_valid at cycle 1, sel=0, gnt=01, then sel=1 with gnt=10, alternating.
- Single requester: req=10, in_data[1]=32'hDEADBEEF, out_ready=1 -> 1 cycle later sel=1, out_data=DEADBEEF, out_valid=1, gnt=10. Held req gives one word per cycle.
- Backpressure: owner 0, out_ready=0 for 3 cycles -> out_valid=1, gnt=00, sel stable. out_ready=1 on cycle 4 -> gnt=01 that cycle only.
- Abandon: OWN1 with out_ready=0, req drops 11->01 -> next cycle OWN0, sel=0, no gnt[1] ever issued.
- Mid-transfer reset: OWN1 with out_valid=1, out_ready=0, reset_n=0 one cycle -> out_valid=0, sel=0, gnt=00, state IDLE.
- ARB2_LOCK_EN: req=11, lock=01, out_ready=1 -> gnt[0] for 4 consecutive cycles. Drop lock -> gnt[1] on the next grant.
